// File: rtl/vend_machine_multi_pkg.sv
// Shared types and helpers for the multi-product vending controller.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_t;

  localparam int unsigned COIN_5  = 5;
  localparam int unsigned COIN_10 = 10;
  localparam int unsigned COIN_20 = 20;

  // Only the three accepted denominations count as coins; anything else is returned.
  function automatic logic is_valid_coin(input int unsigned value);
    return (value == COIN_5) || (value == COIN_10) || (value == COIN_20);
  endfunction

endpackage

// File: rtl/vend_machine_multi_if.sv
// Bundles the coin/selection inputs and dispenser/hopper outputs of the controller.
// Latency: none (wires only).
// Backpressure: change_ready from the hopper holds change_valid/change_amount.
interface vend_machine_multi_if #(
  parameter int NUM_PRODUCTS = 4,
  parameter int CREDIT_W     = 8
);
  localparam int ID_W = $clog2(NUM_PRODUCTS);

  logic                    coin_valid;
  logic [CREDIT_W-1:0]     coin_value;
  logic                    sel_valid;
  logic [ID_W-1:0]         sel_id;
  logic                    cancel;
  logic                    restock_valid;
  logic [ID_W-1:0]         restock_id;
  logic                    change_ready;
  logic                    coin_reject;
  logic                    vend_valid;
  logic [ID_W-1:0]         vend_id;
  logic                    sel_err;
  logic                    change_valid;
  logic [CREDIT_W-1:0]     change_amount;
  logic [CREDIT_W-1:0]     credit;
  logic [NUM_PRODUCTS-1:0] sold_out;
  logic                    busy;

  // Front-end side: coin acceptor, keypad, service port and change hopper.
  modport master (
    output coin_valid, coin_value, sel_valid, sel_id, cancel,
           restock_valid, restock_id, change_ready,
    input  coin_reject, vend_valid, vend_id, sel_err, change_valid,
           change_amount, credit, sold_out, busy
  );

  // Controller side.
  modport slave (
    input  coin_valid, coin_value, sel_valid, sel_id, cancel,
           restock_valid, restock_id, change_ready,
    output coin_reject, vend_valid, vend_id, sel_err, change_valid,
           change_amount, credit, sold_out, busy
  );

endinterface

// File: rtl/vend_machine_multi_stock.sv
// Per-product stock counters with decrement, restock and a registered sold_out vector.
// Latency: counters and sold_out update on the edge after dec/restock is presented.
// Backpressure: none; restock of the decremented product wins and skips the decrement.
module vend_stock #(
  parameter int NUM_PRODUCTS = 4,
  parameter int STOCK_W      = 4,
  parameter int INIT_STOCK   = 8,
  localparam int ID_W        = $clog2(NUM_PRODUCTS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    dec_valid,
  input  logic [ID_W-1:0]         dec_id,
  input  logic                    restock_valid,
  input  logic [ID_W-1:0]         restock_id,
  output logic [NUM_PRODUCTS-1:0] sold_out
);

  logic [STOCK_W-1:0]      stock_q [NUM_PRODUCTS];
  logic [STOCK_W-1:0]      stock_d [NUM_PRODUCTS];
  logic [NUM_PRODUCTS-1:0] sold_out_d;

  // Next counter values: restock overrides, decrement never wraps below zero.
  always_comb begin
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      stock_d[i] = stock_q[i];
      if (restock_valid && (restock_id == ID_W'(i))) begin
        stock_d[i] = STOCK_W'(INIT_STOCK);
      end else if (dec_valid && (dec_id == ID_W'(i)) && (stock_q[i] != '0)) begin
        stock_d[i] = stock_q[i] - 1'b1;
      end
      sold_out_d[i] = (stock_d[i] == '0);
    end
  end

  // Counter and sold_out registers; reset loads every product to full.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PRODUCTS; i++) begin
        stock_q[i] <= STOCK_W'(INIT_STOCK);
      end
      sold_out <= '0;
    end else begin
      for (int i = 0; i < NUM_PRODUCTS; i++) begin
        stock_q[i] <= stock_d[i];
      end
      sold_out <= sold_out_d;
    end
  end

endmodule

// File: rtl/vend_machine_multi.sv
// Multi-product vending controller: credit accumulation, vend, change/refund, restock.
// Latency: selection accepted at edge n -> vend_valid in cycle n+1 -> change_valid from n+2.
// Backpressure: change_valid/change_amount hold until change_ready; coins refused while busy.
module vend_machine_multi
  import vend_pkg::*;
#(
  parameter int NUM_PRODUCTS = 4,
  parameter int CREDIT_W     = 8,
  parameter int MAX_CREDIT   = 100,
  parameter int STOCK_W      = 4,
  parameter int INIT_STOCK   = 8,
  parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICE_VEC = {8'd25, 8'd15, 8'd10, 8'd5}
) (
  input logic                 clk,
  input logic                 reset,
  vend_machine_multi_if.slave bus
);

  localparam int ID_W = $clog2(NUM_PRODUCTS);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ID_W-1:0]     vend_id_q, vend_id_d;
  logic                coin_reject_q, coin_reject_d;
  logic                vend_valid_q, vend_valid_d;
  logic                sel_err_q, sel_err_d;
  logic                change_valid_q, change_valid_d;
  logic [CREDIT_W-1:0] change_amount_q, change_amount_d;
  logic                busy_q, busy_d;

  logic                dec_valid;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_ok;
  logic [CREDIT_W-1:0] sel_price, vend_price, remainder;
  logic                sel_in_range, sel_empty, sel_bad;
  logic [NUM_PRODUCTS-1:0] sold_out;

  // Price table lookup by index; out-of-range ids read as zero and are caught separately.
  function automatic logic [CREDIT_W-1:0] price_of(input logic [ID_W-1:0] id);
    logic [CREDIT_W-1:0] p;
    p = '0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (id == ID_W'(i)) p = PRICE_VEC[i*CREDIT_W +: CREDIT_W];
    end
    return p;
  endfunction

  // Coin acceptance and selection legality, shared by several states.
  always_comb begin
    coin_sum     = {1'b0, credit_q} + {1'b0, bus.coin_value};
    coin_ok      = is_valid_coin(32'(bus.coin_value)) &&
                   (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
    sel_in_range = ({1'b0, bus.sel_id} < (ID_W+1)'(NUM_PRODUCTS));
    sel_price    = price_of(bus.sel_id);
    sel_empty    = 1'b0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (bus.sel_id == ID_W'(i)) sel_empty = sold_out[i];
    end
    sel_bad      = !sel_in_range || sel_empty || (credit_q < sel_price);
    vend_price   = price_of(id_q);
    remainder    = credit_q - vend_price;
  end

  // Next-state and next-output logic; every registered output is computed here.
  always_comb begin
    state_d         = state_q;
    credit_d        = credit_q;
    id_d            = id_q;
    vend_id_d       = vend_id_q;
    coin_reject_d   = 1'b0;
    vend_valid_d    = 1'b0;
    sel_err_d       = 1'b0;
    change_valid_d  = change_valid_q;
    change_amount_d = change_amount_q;
    dec_valid       = 1'b0;

    unique case (state_q)
      IDLE: begin
        sel_err_d = bus.sel_valid;
        if (bus.coin_valid) begin
          if (coin_ok) begin
            credit_d = bus.coin_value;
            state_d  = CREDIT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end
      CREDIT: begin
        if (bus.cancel) begin
          coin_reject_d   = bus.coin_valid;
          change_valid_d  = 1'b1;
          change_amount_d = credit_q;
          state_d         = CHANGE;
        end else if (bus.sel_valid) begin
          coin_reject_d = bus.coin_valid;
          if (sel_bad) begin
            sel_err_d = 1'b1;
          end else begin
            id_d         = bus.sel_id;
            vend_id_d    = bus.sel_id;
            vend_valid_d = 1'b1;
            state_d      = VEND;
          end
        end else if (bus.coin_valid) begin
          if (coin_ok) credit_d = coin_sum[CREDIT_W-1:0];
          else         coin_reject_d = 1'b1;
        end
      end
      VEND: begin
        coin_reject_d = bus.coin_valid;
        sel_err_d     = bus.sel_valid;
        dec_valid     = 1'b1;
        credit_d      = remainder;
        if (remainder != '0) begin
          change_valid_d  = 1'b1;
          change_amount_d = remainder;
          state_d         = CHANGE;
        end else begin
          state_d = IDLE;
        end
      end
      CHANGE: begin
        coin_reject_d = bus.coin_valid;
        sel_err_d     = bus.sel_valid;
        if (change_valid_q && bus.change_ready) begin
          credit_d        = '0;
          change_valid_d  = 1'b0;
          change_amount_d = '0;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == VEND) || (state_d == CHANGE);
  end

  // State and output registers; reset drops any pending change.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      credit_q        <= '0;
      id_q            <= '0;
      vend_id_q       <= '0;
      coin_reject_q   <= 1'b0;
      vend_valid_q    <= 1'b0;
      sel_err_q       <= 1'b0;
      change_valid_q  <= 1'b0;
      change_amount_q <= '0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      id_q            <= id_d;
      vend_id_q       <= vend_id_d;
      coin_reject_q   <= coin_reject_d;
      vend_valid_q    <= vend_valid_d;
      sel_err_q       <= sel_err_d;
      change_valid_q  <= change_valid_d;
      change_amount_q <= change_amount_d;
      busy_q          <= busy_d;
    end
  end

  vend_stock #(
    .NUM_PRODUCTS (NUM_PRODUCTS),
    .STOCK_W      (STOCK_W),
    .INIT_STOCK   (INIT_STOCK)
  ) u_stock (
    .clk           (clk),
    .reset         (reset),
    .dec_valid     (dec_valid),
    .dec_id        (id_q),
    .restock_valid (bus.restock_valid),
    .restock_id    (bus.restock_id),
    .sold_out      (sold_out)
  );

  assign bus.coin_reject   = coin_reject_q;
  assign bus.vend_valid    = vend_valid_q;
  assign bus.vend_id       = vend_id_q;
  assign bus.sel_err       = sel_err_q;
  assign bus.change_valid  = change_valid_q;
  assign bus.change_amount = change_amount_q;
  assign bus.credit        = credit_q;
  assign bus.sold_out      = sold_out;
  assign bus.busy          = busy_q;

endmodule
